// File: rtl/lcd_pkg.sv
// Shared LCD frame-buffer definitions: default widths, panel geometry and
// the arbiter grant encoding.
package lcd_pkg;

  localparam int LCD_AW       = 19;
  localparam int LCD_DW       = 24;
  localparam int LCD_WW       = 16;
  localparam int LCD_H_ACTIVE = 800;
  localparam int LCD_V_ACTIVE = 480;

  typedef enum logic [1:0] {
    G_NONE = 2'b00,
    G_DISP = 2'b01,
    G_WR   = 2'b10
  } grant_e;

endpackage

// File: rtl/lcd_rd_pipe.sv
// Read-return delay line: two-stage valid shift following display grants,
// with RAM read data captured into a single output register.
module lcd_rd_pipe
  import lcd_pkg::*;
#(
  parameter int DW = LCD_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_grant,
  input  logic [DW-1:0] mem_rdata,
  output logic          rvalid,
  output logic [DW-1:0] rdata
);

  logic rd_stage;

  // Valid shift and data capture; RAM data is present the cycle after the grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_stage <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= {DW{1'b0}};
    end else begin
      rd_stage <= rd_grant;
      rvalid   <= rd_stage;
      if (rd_stage) begin
        rdata <= mem_rdata;
      end else begin
        rdata <= rdata;
      end
    end
  end

endmodule

// File: rtl/lcd_fb_arbiter.sv
// Single-port frame-buffer arbiter: display reads always win, the writer is
// served in free cycles (never twice in a row), and writer waits are tracked.
module lcd_fb_arbiter
  import lcd_pkg::*;
#(
  parameter int AW = LCD_AW,
  parameter int DW = LCD_DW,
  parameter int WW = LCD_WW
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_rvalid,
  output logic [DW-1:0] disp_rdata,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [WW-1:0] wr_wait_max
);

  localparam logic [WW-1:0] WAIT_SAT = {WW{1'b1}};
  localparam logic [WW-1:0] WAIT_ONE = {{(WW-1){1'b0}}, 1'b1};

  grant_e        state;
  grant_e        next_state;
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] wait_cnt_next;

  // Grant decision and writer wait accounting for the coming edge.
  always_comb begin
    next_state    = G_NONE;
    wait_cnt_next = wait_cnt;
    if (disp_req) begin
      next_state = G_DISP;
    end else if (wr_req && (state != G_WR)) begin
      next_state = G_WR;
    end else begin
      next_state = G_NONE;
    end
    // The cycle right after an ack carries a stale request; it is not a wait.
    if (next_state == G_WR) begin
      wait_cnt_next = {WW{1'b0}};
    end else if (wr_req && (state != G_WR) && (wait_cnt != WAIT_SAT)) begin
      wait_cnt_next = wait_cnt + WAIT_ONE;
    end else begin
      wait_cnt_next = wait_cnt;
    end
  end

  // Grant state, registered RAM controls and wait statistics.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state       <= G_NONE;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      wr_ack      <= 1'b0;
      mem_addr    <= {AW{1'b0}};
      mem_wdata   <= {DW{1'b0}};
      wait_cnt    <= {WW{1'b0}};
      wr_wait_max <= {WW{1'b0}};
    end else begin
      state    <= next_state;
      mem_en   <= (next_state != G_NONE);
      mem_we   <= (next_state == G_WR);
      wr_ack   <= (next_state == G_WR);
      wait_cnt <= wait_cnt_next;
      if (wait_cnt_next > wr_wait_max) begin
        wr_wait_max <= wait_cnt_next;
      end else begin
        wr_wait_max <= wr_wait_max;
      end
      case (next_state)
        G_DISP: begin
          mem_addr <= disp_addr;
        end
        G_WR: begin
          mem_addr  <= wr_addr;
          mem_wdata <= wr_data;
        end
        default: begin
          mem_addr  <= mem_addr;
          mem_wdata <= mem_wdata;
        end
      endcase
    end
  end

  lcd_rd_pipe #(.DW(DW)) u_rd_pipe (
    .clk       (CLK),
    .rst_n     (RST_n),
    .rd_grant  (state == G_DISP),
    .mem_rdata (mem_rdata),
    .rvalid    (disp_rvalid),
    .rdata     (disp_rdata)
  );

endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// Scoreboard bench for lcd_fb_arbiter: a rule-level model predicts grants,
// read data/latency and wait statistics; a monitor checks read returns.
module tb_lcd_fb_arbiter;
  import lcd_pkg::*;

  localparam int AW = LCD_AW;
  localparam int DW = LCD_DW;
  localparam int WW = LCD_WW;
  localparam int NWORDS = 4096;
  localparam int CNT_SAT = (1 << WW) - 1;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RST_n, disp_req, wr_req;
  logic [AW-1:0] disp_addr, wr_addr;
  logic [DW-1:0] wr_data;
  logic          disp_rvalid, wr_ack, mem_en, mem_we;
  logic [DW-1:0] disp_rdata, mem_wdata, ram_rdata;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] wr_wait_max;
  logic          dv4, ack4, en4, we4;
  logic [DW-1:0] drd4, wd4;
  logic [AW-1:0] addr4;
  logic [3:0]    max4;

  lcd_fb_arbiter dut (
    .CLK(CLK), .RST_n(RST_n), .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(ram_rdata), .wr_wait_max(wr_wait_max)
  );

  lcd_fb_arbiter #(.WW(4)) dut4 (
    .CLK(CLK), .RST_n(RST_n), .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_rvalid(dv4), .disp_rdata(drd4), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(ack4), .mem_en(en4),
    .mem_we(we4), .mem_addr(addr4), .mem_wdata(wd4),
    .mem_rdata(ram_rdata), .wr_wait_max(max4)
  );

  // Behavioural single-port RAM, preloaded with data = address.
  logic [DW-1:0] ram [0:NWORDS-1];
  bit ram_loaded = 1'b0;
  always @(posedge CLK) begin
    if (!ram_loaded) begin
      for (int i = 0; i < NWORDS; i++) ram[i] <= DW'(i);
      ram_loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr[11:0]] <= mem_wdata;
      else ram_rdata <= ram[mem_addr[11:0]];
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;
  int n_ack_seen = 0;
  int n_we_seen = 0;
  bit mon_on = 1'b0;

  typedef struct { logic [DW-1:0] data; int due; } rd_t;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  rd_t rq[$];
  wr_t wq[$];

  logic [DW-1:0] ref_mem [0:NWORDS-1];
  bit            m_prev_wr;
  int            m_cnt, m_max;
  logic          e_en, e_we, e_ack;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_wr(input int a, input int d);
    wr_t w;
    w.a = AW'(a);
    w.d = DW'(d);
    wq.push_back(w);
  endtask

  // One clock: model the coming edge from the arbitration rules, then check.
  task automatic tick();
    bit gw;
    rd_t e;
    gw = 1'b0;
    if (!wr_req && wq.size() > 0) begin
      wr_req = 1'b1; wr_addr = wq[0].a; wr_data = wq[0].d;
    end
    if (!RST_n) begin
      m_prev_wr = 1'b0; m_cnt = 0; m_max = 0;
      e_en = 1'b0; e_we = 1'b0; e_ack = 1'b0; e_addr = '0; e_wdata = '0;
      for (int i = rq.size() - 1; i >= 0; i--) if (rq[i].due > cyc) rq.delete(i);
    end else begin
      gw = wr_req && !disp_req && !m_prev_wr;
      if (gw) begin
        m_cnt = 0;
        ref_mem[wr_addr[11:0]] = wr_data;
        e_addr = wr_addr; e_wdata = wr_data;
      end else if (wr_req && !m_prev_wr && m_cnt < CNT_SAT) begin
        m_cnt++;
      end
      if (m_cnt > m_max) m_max = m_cnt;
      if (disp_req) begin
        e.data = ref_mem[disp_addr[11:0]];
        e.due = cyc + 3;
        rq.push_back(e);
        e_addr = disp_addr;
      end
      e_en = disp_req || gw; e_we = gw; e_ack = gw; m_prev_wr = gw;
    end
    @(posedge CLK);
    @(negedge CLK);
    chk("mem_en", 32'(mem_en), 32'(e_en));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("wr_ack", 32'(wr_ack), 32'(e_ack));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    chk("wr_wait_max", 32'(wr_wait_max), 32'(m_max));
    chk("wr_wait_max_ww4", 32'(max4), 32'((m_max > 15) ? 15 : m_max));
    if (wr_ack) n_ack_seen++;
    if (mem_we) n_we_seen++;
    if (gw) begin
      void'(wq.pop_front());
      wr_req = 1'b0;
    end
    mon_on = 1'b1;
  endtask

  task automatic idle(input int n);
    disp_req = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    disp_req = 1'b0;
    while ((wq.size() > 0 || rq.size() > 0) && n < max_cycles) begin
      tick();
      n++;
    end
    chk("drain_pending", 32'(wq.size() + rq.size()), 32'd0);
  endtask

  // Read-return monitor: each expected word must appear exactly on its due cycle.
  always @(negedge CLK) begin
    if (mon_on) begin
      if (rq.size() > 0 && rq[0].due == cyc) begin
        chk("disp_rvalid", 32'(disp_rvalid), 32'd1);
        chk("disp_rdata", 32'(disp_rdata), 32'(rq[0].data));
        void'(rq.pop_front());
      end else begin
        chk("disp_rvalid_idle", 32'(disp_rvalid), 32'd0);
      end
    end
  end

  initial begin
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = DW'(i);
    m_prev_wr = 1'b0; m_cnt = 0; m_max = 0;
    RST_n = 1'b0; disp_req = 1'b1; disp_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;

    // Reset held with both requesters active; display wins on release.
    push_wr(4000, 7);
    for (int i = 0; i < 20; i++) tick();
    RST_n = 1'b1;
    disp_addr = AW'(1);
    tick();
    idle(4);

    // Full-line read burst, one word per cycle.
    for (int i = 0; i < LCD_H_ACTIVE; i++) begin
      disp_req = 1'b1; disp_addr = AW'(i); tick();
    end
    idle(5);

    // Blanking writes, then readback.
    n_ack_seen = 0; n_we_seen = 0;
    for (int i = 0; i < 4; i++) push_wr(32'h100 + i, 32'hFF0000);
    drain(50);
    chk("blank_ack_count", 32'(n_ack_seen), 32'd4);
    chk("blank_we_count", 32'(n_we_seen), 32'd4);
    for (int i = 0; i < 4; i++) begin
      disp_req = 1'b1; disp_addr = AW'(32'h100 + i); tick();
    end
    idle(5);

    // Same-address conflict during a display burst.
    push_wr(5, 32'h123456);
    for (int i = 0; i < 10; i++) begin
      disp_req = 1'b1; disp_addr = AW'(i); tick();
    end
    idle(4);
    chk("conflict_wait_max", 32'(wr_wait_max), 32'd10);

    // Writer starved for 40 cycles; narrow counter saturates.
    push_wr(4001, 32'hABCDEF);
    for (int i = 0; i < 40; i++) begin
      disp_req = 1'b1; disp_addr = AW'($urandom_range(0, NWORDS - 1)); tick();
    end
    idle(4);
    chk("sat_wait_max_ww4", 32'(max4), 32'd15);
    chk("sat_wait_max", 32'(wr_wait_max), 32'd40);

    // Reset one cycle into a 3-read burst with a write pending.
    push_wr(4002, 32'h0F0F0F);
    disp_req = 1'b1; disp_addr = AW'(10); tick();
    RST_n = 1'b0;
    disp_addr = AW'(11); tick();
    disp_addr = AW'(12); tick();
    disp_req = 1'b0; tick();
    RST_n = 1'b1;
    idle(6);

    // Randomised traffic with occasional blanking periods.
    for (int i = 0; i < 3000; i++) begin
      if ((i % 200) < 150) disp_req = ($urandom_range(0, 7) != 0);
      else disp_req = ($urandom_range(0, 7) == 0);
      disp_addr = AW'($urandom_range(1024, NWORDS - 1));
      if (wq.size() < 2 && $urandom_range(0, 3) == 0)
        push_wr($urandom_range(1024, NWORDS - 1), $urandom_range(0, 32'hFFFFFF));
      tick();
    end
    drain(200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_fb_arbiter.md
# lcd_fb_arbiter

Single-port frame-buffer arbiter for the LCD image path. It shares one synchronous single-port RAM between two requesters. The first is the display scan-out reader, which fetches pixels ahead of DEN for the LCD timing generator. The second is a pixel writer, such as an image loader or drawing engine. Display reads always win. The writer is served in any cycle the display leaves free, normally horizontal/vertical blanking.

## Interface
Parameters:
- AW, 19, frame-buffer address width (800×480 = 384000 words).
- DW, 24, pixel width (R,G,B 8 bits each).
- WW, 16, width of the writer wait statistics counter.

Ports:
- CLK  in  1  system clock; single clock domain.
- RST_n  in  1  reset, synchronous and active-low.
- disp_req  in  1  display read request, one word per asserted cycle.
- disp_addr  in  AW  read address, valid with disp_req.
- disp_rvalid  out  1  read data valid.
- disp_rdata  out  DW  read data, in request order.
- wr_req  in  1  writer request; held until acked.
- wr_addr  in  AW  write address, stable while wr_req=1.
- wr_data  in  DW  write data, stable while wr_req=1.
- wr_ack  out  1  one-cycle pulse; write committed this cycle.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid one cycle after mem_en with mem_we=0.
- wr_wait_max  out  WW  longest writer wait observed, in cycles, saturating.

## Operation
- Grant FSM with states G_NONE, G_DISP and G_WR. The state is the grant driving the RAM in the current cycle. Next state is decided at each CLK edge:
  - disp_req=1 → G_DISP, regardless of wr_req.
  - else wr_req=1 and state≠G_WR → G_WR.
  - else → G_NONE.
- G_WR is never taken twice in a row. The writer sees wr_ack at the next edge, and the mandatory gap keeps a stale request from causing a double write. Peak write rate is 1 per 2 cycles.
- G_DISP drives mem_en=1, mem_we=0, mem_addr=registered disp_addr.
- G_WR drives mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1.
- G_NONE drives mem_en=0 and mem_we=0. mem_addr and mem_wdata hold their last values.
- Read return path: a 2-stage valid shift register follows the G_DISP grants. disp_rdata is mem_rdata registered. Order is preserved and there is no backpressure, so the display consumer must always accept data.
- Same-address conflict: a display read and a pending write to the same address are never in the same cycle. The read returns the pre-write contents.
- Writer wait counter:
  - Increments every cycle with wr_req=1 and wr_ack=0.
  - Clears on wr_ack.
  - wr_wait_max is updated whenever the counter exceeds it.
  - Both saturate at 2^WW−1.

## Timing
- Reset, taking effect at the first edge with RST_n=0:
  - state=G_NONE.
  - mem_en, mem_we, wr_ack and disp_rvalid are 0.
  - mem_addr, mem_wdata and disp_rdata are 0.
  - The valid pipeline is flushed.
  - The wait counter and wr_wait_max are 0.
- Reset mid-operation: in-flight reads are dropped with no disp_rvalid. A write granted in the reset cycle itself is not issued.
- Read latency: disp_req sampled at edge k gives mem_en at k..k+1, then disp_rvalid and disp_rdata at k+2..k+3. That is 3 edges from request to data. The display fetcher prefetches at least 3 words ahead of DEN.
- Back-to-back disp_req gives one word per cycle with continuous disp_rvalid.
- Write: wr_req seen at edge k with disp_req=0 and state≠G_WR gives mem_we=1 and wr_ack=1 in cycle k..k+1.
- Simultaneous disp_req and wr_req: the display is granted and the writer waits. The writer is granted at the first edge with disp_req=0.
- Writer starvation during active video is permitted. It is reported only through wr_wait_max, with no preemption.

## Structure
- Shared package lcd_pkg holds:
  - Default AW, DW and WW (LCD_AW, LCD_DW, LCD_WW).
  - The grant state enum (G_NONE/G_DISP/G_WR, 2-bit encoding 00/01/10).
  - LCD_H_ACTIVE=800 and LCD_V_ACTIVE=480.
- One natural sub-module: lcd_rd_pipe, the parameterised valid/data delay line (depth 2 valid, 1 data register).
- The grant FSM and wait counter stay in the top module.

## Test plan
- Reset: RST_n=0 for 20 cycles with wr_req=1 and disp_req=1 → mem_en=0, wr_ack=0, disp_rvalid=0 and wr_wait_max=0 throughout. Release → display granted first.
- Read burst: RAM preloaded with data=addr. disp_req for 800 cycles, addr 0..799 → disp_rvalid high for 800 cycles starting 3 edges later, disp_rdata 0..799 in order, no gaps.
- Write in blanking: disp_req=0, writer issues 4 writes at 0x100..0x103 with data 0xFF0000 → exactly 4 wr_ack pulses spaced 2 cycles apart, 4 mem_we pulses. Readback returns 0xFF0000.
- Conflict: wr_req to addr 5 (data 0x123456) during a 10-cycle disp_req burst over addr 0..9 (RAM preloaded data=addr) → no wr_ack during the burst, and the read of addr 5 returns 0x000005. wr_ack comes 1 cycle after the burst ends. wr_wait_max=10.
- Saturation: WW=4, wr_req held under 40 cycles of disp_req → wr_wait_max=15, then the write is acked.
- Mid-op reset: RST_n=0 one cycle after a 3-read burst is issued → none of those 3 reads produce disp_rvalid, and no write occurs.
